// File: rtl/score_seg_driver.sv
// Score display driver: converts a binary score to BCD with a double-dabble
// engine and time-multiplexes a 4-digit active-low 7-segment display.
module score_seg_driver #(
   parameter int SCAN_PERIOD   = 100000,
   parameter bit BLANK_LEADING = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [13:0] score_in,
   input  logic        score_valid,
   output logic        busy,
   output logic [3:0]  AN,
   output logic [7:0]  SEGMENT
);

   localparam int PW = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CONV   = 2'd1,
      COMMIT = 2'd2
   } state_t;

   function automatic logic [13:0] saturate(input logic [13:0] v);
      if (v > 14'd9999) return 14'd9999;
      else return v;
   endfunction

   // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift.
   function automatic logic [15:0] dd_adjust(input logic [15:0] b);
      logic [15:0] r;
      r = b;
      for (int k = 0; k < 4; k++) begin
         if (b[k*4 +: 4] >= 4'd5) r[k*4 +: 4] = b[k*4 +: 4] + 4'd3;
         else r[k*4 +: 4] = b[k*4 +: 4];
      end
      return r;
   endfunction

   function automatic logic [7:0] seg_decode(input logic [3:0] n);
      case (n)
         4'd0:    return 8'hC0;
         4'd1:    return 8'hF9;
         4'd2:    return 8'hA4;
         4'd3:    return 8'hB0;
         4'd4:    return 8'h99;
         4'd5:    return 8'h92;
         4'd6:    return 8'h82;
         4'd7:    return 8'hF8;
         4'd8:    return 8'h80;
         4'd9:    return 8'h90;
         default: return 8'hFF;
      endcase
   endfunction

   state_t         state_r;
   logic [13:0]    bin_r;
   logic [15:0]    acc_r;
   logic [3:0]     iter_r;
   logic [15:0]    disp_r;
   logic           pending_r;
   logic [13:0]    pend_val_r;
   logic [PW-1:0]  presc_r;
   logic [1:0]     idx_r;

   logic [13:0]    sat_s;
   logic [15:0]    adj_s;
   logic [1:0]     idx_nxt_s;
   logic [3:0]     nib_s;
   logic           blank_s;
   logic [7:0]     seg_nxt_s;

   // Saturated input and nibble correction of the running accumulator.
   always_comb begin
      sat_s = saturate(score_in);
      adj_s = dd_adjust(acc_r);
   end

   // Conversion FSM with one-deep pending buffer; busy mirrors state != IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         busy       <= 1'b0;
         bin_r      <= 14'd0;
         acc_r      <= 16'd0;
         iter_r     <= 4'd0;
         disp_r     <= 16'd0;
         pending_r  <= 1'b0;
         pend_val_r <= 14'd0;
      end else begin
         case (state_r)
            IDLE: begin
               if (pending_r) begin
                  bin_r   <= pend_val_r;
                  acc_r   <= 16'd0;
                  iter_r  <= 4'd0;
                  state_r <= CONV;
                  busy    <= 1'b1;
                  // A strobe in this cycle queues behind the pending value.
                  pending_r <= score_valid;
                  if (score_valid) pend_val_r <= sat_s;
               end else if (score_valid) begin
                  bin_r   <= sat_s;
                  acc_r   <= 16'd0;
                  iter_r  <= 4'd0;
                  state_r <= CONV;
                  busy    <= 1'b1;
               end else begin
                  busy <= 1'b0;
               end
            end
            CONV: begin
               acc_r  <= {adj_s[14:0], bin_r[13]};
               bin_r  <= {bin_r[12:0], 1'b0};
               iter_r <= iter_r + 4'd1;
               busy   <= 1'b1;
               if (iter_r == 4'd13) state_r <= COMMIT;
               if (score_valid) begin
                  pending_r  <= 1'b1;
                  pend_val_r <= sat_s;
               end
            end
            COMMIT: begin
               disp_r  <= acc_r;
               state_r <= IDLE;
               busy    <= 1'b0;
               if (score_valid) begin
                  pending_r  <= 1'b1;
                  pend_val_r <= sat_s;
               end
            end
            default: begin
               state_r <= IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

   // Segment pattern for the digit that becomes active at the next wrap.
   always_comb begin
      idx_nxt_s = idx_r + 2'd1;
      nib_s     = 4'd0;
      blank_s   = 1'b0;
      case (idx_nxt_s)
         2'd0: begin nib_s = disp_r[3:0];   blank_s = 1'b0;                     end
         2'd1: begin nib_s = disp_r[7:4];   blank_s = (disp_r[15:4] == 12'd0);  end
         2'd2: begin nib_s = disp_r[11:8];  blank_s = (disp_r[15:8] == 8'd0);   end
         2'd3: begin nib_s = disp_r[15:12]; blank_s = (disp_r[15:12] == 4'd0);  end
         default: begin nib_s = 4'd0; blank_s = 1'b0; end
      endcase
      if (BLANK_LEADING && blank_s) seg_nxt_s = 8'hFF;
      else seg_nxt_s = seg_decode(nib_s);
   end

   // Scan prescaler; AN and SEGMENT load together on the wrap edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_r <= '0;
         idx_r   <= 2'd0;
         AN      <= 4'b1110;
         SEGMENT <= 8'hC0;
      end else if (presc_r == PW'(SCAN_PERIOD - 1)) begin
         presc_r <= '0;
         idx_r   <= idx_nxt_s;
         AN      <= ~(4'b0001 << idx_nxt_s);
         SEGMENT <= seg_nxt_s;
      end else begin
         presc_r <= presc_r + PW'(1);
      end
   end

endmodule

// File: tb/tb_score_seg_driver.sv
// Directed self-checking bench for score_seg_driver (SCAN_PERIOD=4), with a
// second instance built with leading-zero blanking disabled.
module tb_score_seg_driver;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [13:0] score_in = 14'd0;
   logic        score_valid = 1'b0;
   logic        busy, busy0;
   logic [3:0]  an, an0;
   logic [7:0]  seg, seg0;

   int checks = 0;
   int errors = 0;
   logic [7:0] obs [4];
   logic [7:0] obs0 [4];

   always #5 clk = ~clk;

   score_seg_driver #(.SCAN_PERIOD(4), .BLANK_LEADING(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .score_in(score_in), .score_valid(score_valid),
      .busy(busy), .AN(an), .SEGMENT(seg));

   score_seg_driver #(.SCAN_PERIOD(4), .BLANK_LEADING(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .score_in(score_in), .score_valid(score_valid),
      .busy(busy0), .AN(an0), .SEGMENT(seg0));

   function automatic int an_pos(input logic [3:0] a);
      case (a)
         4'b1110: return 0;
         4'b1101: return 1;
         4'b1011: return 2;
         4'b0111: return 3;
         default: return -1;
      endcase
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic strobe(input logic [13:0] v);
      score_in    = v;
      score_valid = 1'b1;
      tick();
      score_valid = 1'b0;
   endtask

   // Let the scan refresh every digit, then record one full scan of both DUTs.
   task automatic read_display;
      bit bad_an;
      bad_an = 1'b0;
      for (int k = 0; k < 4; k++) begin
         obs[k]  = 8'h00;
         obs0[k] = 8'h00;
      end
      repeat (16) tick();
      for (int i = 0; i < 16; i++) begin
         tick();
         if (an_pos(an) < 0 || an_pos(an0) < 0) bad_an = 1'b1;
         else begin
            obs[an_pos(an)]   = seg;
            obs0[an_pos(an0)] = seg0;
         end
      end
      checks++;
      if (bad_an !== 1'b0) begin
         errors++;
         $display("FAIL an_onehot: observed AN=%b/%b, required one-hot-low", an, an0);
      end
   endtask

   task automatic test_reset;
      logic [3:0] exp_an [4];
      logic [7:0] exp_seg [4];
      exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      exp_seg = '{8'hC0, 8'hFF, 8'hFF, 8'hFF};
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (6) tick();
      rst_n = 1'b0;
      #1;
      checks += 3;
      if (an !== 4'b1110) begin errors++; $display("FAIL reset_an: got %b want 1110", an); end
      if (seg !== 8'hC0) begin errors++; $display("FAIL reset_seg: got %h want c0", seg); end
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      #3;
      rst_n = 1'b1;
      for (int i = 0; i < 16; i++) begin
         checks += 2;
         if (an !== exp_an[i/4]) begin
            errors++; $display("FAIL idle_an[%0d]: got %b want %b", i, an, exp_an[i/4]);
         end
         if (seg !== exp_seg[i/4]) begin
            errors++; $display("FAIL idle_seg[%0d]: got %h want %h", i, seg, exp_seg[i/4]);
         end
         tick();
      end
   endtask

   task automatic test_normal;
      int cnt;
      logic [7:0] e [4];
      e = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
      strobe(14'd1234);
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (busy) cnt++;
         else break;
         tick();
      end
      checks++;
      if (cnt != 15) begin errors++; $display("FAIL busy_len: got %0d want 15", cnt); end
      read_display();
      for (int k = 0; k < 4; k++) begin
         checks += 2;
         if (obs[k] !== e[k]) begin errors++; $display("FAIL n1234_d%0d: got %h want %h", k, obs[k], e[k]); end
         if (obs0[k] !== e[k]) begin errors++; $display("FAIL n1234_nb_d%0d: got %h want %h", k, obs0[k], e[k]); end
      end
   endtask

   task automatic test_blank;
      logic [7:0] e [4];
      logic [7:0] f [4];
      strobe(14'd7);
      repeat (20) tick();
      read_display();
      e = '{8'hF8, 8'hFF, 8'hFF, 8'hFF};
      f = '{8'hF8, 8'hC0, 8'hC0, 8'hC0};
      for (int k = 0; k < 4; k++) begin
         checks += 2;
         if (obs[k] !== e[k]) begin errors++; $display("FAIL blank7_d%0d: got %h want %h", k, obs[k], e[k]); end
         if (obs0[k] !== f[k]) begin errors++; $display("FAIL noblank7_d%0d: got %h want %h", k, obs0[k], f[k]); end
      end
      // Interior zeros below a nonzero digit must stay lit.
      strobe(14'd100);
      repeat (20) tick();
      read_display();
      e = '{8'hC0, 8'hC0, 8'hF9, 8'hFF};
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (obs[k] !== e[k]) begin errors++; $display("FAIL blank100_d%0d: got %h want %h", k, obs[k], e[k]); end
      end
   endtask

   task automatic test_saturate;
      strobe(14'd12000);
      repeat (20) tick();
      read_display();
      for (int k = 0; k < 4; k++) begin
         checks += 2;
         if (obs[k] !== 8'h90) begin errors++; $display("FAIL sat_d%0d: got %h want 90", k, obs[k]); end
         if (obs0[k] !== 8'h90) begin errors++; $display("FAIL sat_nb_d%0d: got %h want 90", k, obs0[k]); end
      end
   endtask

   task automatic test_pending;
      bit exp_busy;
      bit saw_42;
      bit saw_305;
      logic [7:0] e [4];
      saw_42  = 1'b0;
      saw_305 = 1'b0;
      strobe(14'd42);
      for (int k = 0; k <= 32; k++) begin
         exp_busy = (k <= 14) || (k >= 16 && k <= 30);
         checks++;
         if (busy !== exp_busy) begin
            errors++; $display("FAIL pend_busy[%0d]: got %b want %b", k, busy, exp_busy);
         end
         if (k >= 16 && k <= 31 && an == 4'b1101 && seg == 8'h99) saw_42 = 1'b1;
         if (an == 4'b1011 && seg == 8'hB0) saw_305 = 1'b1;
         score_valid = 1'b0;
         if (k == 1) begin score_in = 14'd305; score_valid = 1'b1; end
         if (k == 6) begin score_in = 14'd8;   score_valid = 1'b1; end
         tick();
      end
      score_valid = 1'b0;
      checks += 2;
      if (saw_42 !== 1'b1) begin errors++; $display("FAIL pend_42_shown: got %b want 1", saw_42); end
      if (saw_305 !== 1'b0) begin errors++; $display("FAIL pend_305_hidden: got %b want 0", saw_305); end
      read_display();
      e = '{8'h80, 8'hFF, 8'hFF, 8'hFF};
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (obs[k] !== e[k]) begin errors++; $display("FAIL pend8_d%0d: got %h want %h", k, obs[k], e[k]); end
      end
   endtask

   task automatic test_reset_mid;
      bit busy_seen;
      logic [7:0] e [4];
      busy_seen = 1'b0;
      strobe(14'd9876);
      repeat (7) tick();
      rst_n = 1'b0;
      #1;
      checks += 3;
      if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b want 0", busy); end
      if (an !== 4'b1110) begin errors++; $display("FAIL rmid_an: got %b want 1110", an); end
      if (seg !== 8'hC0) begin errors++; $display("FAIL rmid_seg: got %h want c0", seg); end
      #3;
      rst_n = 1'b1;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (busy !== 1'b0) busy_seen = 1'b1;
      end
      checks++;
      if (busy_seen !== 1'b0) begin errors++; $display("FAIL rmid_stale_busy: got %b want 0", busy_seen); end
      read_display();
      e = '{8'hC0, 8'hFF, 8'hFF, 8'hFF};
      for (int k = 0; k < 4; k++) begin
         checks += 2;
         if (obs[k] !== e[k]) begin errors++; $display("FAIL rmid_d%0d: got %h want %h", k, obs[k], e[k]); end
         if (obs0[k] !== 8'hC0) begin errors++; $display("FAIL rmid_nb_d%0d: got %h want c0", k, obs0[k]); end
      end
   endtask

   initial begin
      test_reset();
      test_normal();
      test_blank();
      test_saturate();
      test_pending();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
